// File: rtl/pipe_trace_monitor.sv
// pipe_trace_monitor -- triggered multi-channel trace capture.
//
// Arms on a pulse, waits for channel trig_ch of the probe bus to equal
// trig_value, then records the full probe bus into a DEPTH-entry buffer
// starting at entry 0 until the effective post_count entries are held.
// The buffer can be read back one channel at a time while IDLE or DONE.
//
// Optional feature: define PIPE_TRACE_SIGNATURE_EN to build a rolling
// signature (rotate-left-1 XOR trigger-channel value) over every buffer
// write. Without it, signature is tied to zero.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   arm, abort        start a capture / cancel back to IDLE (abort wins)
//   probe_valid/probe probe bus; channel k at probe[k*WIDTH +: WIDTH]
//   trig_ch/value     trigger channel select and match value
//   post_count        entries to capture incl. trigger (0 or >DEPTH = DEPTH)
//   rd_en/addr/ch     readout request, entry, channel
//   rd_data/rd_valid  readout result, one cycle after rd_en
//   state, done       FSM state (IDLE=0 ARMED=1 CAPTURE=2 DONE=3), DONE flag
//   count             entries captured
//   trig_cycle        free-running cycle counter latched on trigger
//   signature         rolling signature of captured trigger-channel data
module pipe_trace_monitor #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 7,
  parameter int DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          probe_valid,
  input  logic [CHANNELS*WIDTH-1:0]     probe,
  input  logic [$clog2(CHANNELS)-1:0]   trig_ch,
  input  logic [WIDTH-1:0]              trig_value,
  input  logic [$clog2(DEPTH):0]        post_count,
  input  logic                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  input  logic [$clog2(CHANNELS)-1:0]   rd_ch,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [1:0]                    state,
  output logic                          done,
  output logic [$clog2(DEPTH):0]        count,
  output logic [31:0]                   trig_cycle,
  output logic [WIDTH-1:0]              signature
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = $clog2(CHANNELS);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  // One extra bit so CHANNELS itself is representable for range checks.
  localparam logic [CHW:0]   NCH     = (CHW+1)'(CHANNELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                     state_q;
  logic [31:0]                cycle_cnt;
  logic [CHANNELS*WIDTH-1:0]  mem [DEPTH];

  logic [CW-1:0]              eff_post;
  logic [WIDTH-1:0]           trig_sample;
  logic                       trigger;
  logic                       cap_wr;
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic [CW-1:0]              count_inc;
  logic [CHANNELS*WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]           rd_sel;
  logic                       rd_hit;
  logic                       rd_allowed;

  assign state = state_q;

  // NOTE: every variable driven here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_post    = ((post_count == '0) || (post_count > DEPTH_C)) ? DEPTH_C : post_count;
    trig_sample = '0;
    rd_sel      = '0;
    rd_word     = mem[rd_addr];
    for (int k = 0; k < CHANNELS; k++) begin
      if (trig_ch == CHW'(k)) trig_sample = probe[k*WIDTH +: WIDTH];
      if (rd_ch == CHW'(k))   rd_sel      = rd_word[k*WIDTH +: WIDTH];
    end
    // An out-of-range trig_ch leaves trig_sample at 0, so the range test
    // is what stops a zero trig_value from matching a missing channel.
    trigger    = (state_q == ARMED) && !abort && probe_valid &&
                 ({1'b0, trig_ch} < NCH) && (trig_sample == trig_value);
    cap_wr     = (state_q == CAPTURE) && !abort && probe_valid;
    wr_en      = trigger || cap_wr;
    wr_addr    = trigger ? '0 : count[AW-1:0];
    count_inc  = trigger ? CW'(1) : count + CW'(1);
    rd_hit     = ({1'b0, rd_addr} < count) && ({1'b0, rd_ch} < NCH);
    rd_allowed = (state_q == IDLE) || (state_q == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      done       <= 1'b0;
      count      <= '0;
      trig_cycle <= '0;
    end else if (abort) begin
      // Captured data, count and trig_cycle stay readable after an abort.
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q <= ARMED;
            done    <= 1'b0;
            count   <= '0;
          end
        end
        ARMED: begin
          if (trigger) begin
            count      <= count_inc;
            trig_cycle <= cycle_cnt;
            if (eff_post == CW'(1)) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (cap_wr) begin
            count <= count_inc;
            // >= keeps count bounded even if post_count drops mid-capture.
            if (count_inc >= eff_post) begin
              state_q <= DONE;
              done    <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the trace buffer is deliberately not reset; reads are gated by
  // count, which is, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= probe;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en && rd_allowed) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_hit ? rd_sel : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef PIPE_TRACE_SIGNATURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signature <= '0;
    end else if (!abort && arm && rd_allowed) begin
      signature <= '0;
    end else if (wr_en) begin
      signature <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ trig_sample;
    end
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Self-checking bench for pipe_trace_monitor at default parameters.
// Readout expectations are queued when a read is issued and compared by a
// separate monitor whenever rd_valid is seen; status outputs are checked
// directly after the relevant clock edge.
module tb_pipe_trace_monitor;
  localparam int W  = 32;
  localparam int CH = 7;
  localparam int D  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            arm = 1'b0;
  logic            abort = 1'b0;
  logic            probe_valid = 1'b0;
  logic [CH*W-1:0] probe = '0;
  logic [2:0]      trig_ch = '0;
  logic [W-1:0]    trig_value = '0;
  logic [4:0]      post_count = '0;
  logic            rd_en = 1'b0;
  logic [3:0]      rd_addr = '0;
  logic [2:0]      rd_ch = '0;
  logic [W-1:0]    rd_data;
  logic            rd_valid;
  logic [1:0]      state;
  logic            done;
  logic [4:0]      count;
  logic [31:0]     trig_cycle;
  logic [W-1:0]    signature;

  pipe_trace_monitor #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .probe_valid(probe_valid), .probe(probe), .trig_ch(trig_ch),
    .trig_value(trig_value), .post_count(post_count), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .done(done), .count(count), .trig_cycle(trig_cycle),
    .signature(signature)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int unsigned cyc_model;
  logic [31:0] exp_tc;

  // Reference cycle count: edges seen since reset was released.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc_model <= 0;
    else        cyc_model <= cyc_model + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Readout monitor.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h, expected no readout", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  // Channel k carries v ^ (k<<16) so each channel of an entry is distinct.
  function automatic logic [CH*W-1:0] make_bus(input logic [31:0] v);
    logic [CH*W-1:0] b;
    for (int k = 0; k < CH; k++) b[k*W +: W] = v ^ (32'(k) << 16);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] v, input logic valid);
    probe       = make_bus(v);
    probe_valid = valid;
    step();
    probe_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [2:0] c, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    rd_ch   = c;
    exp_q.push_back(exp);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_trig_cycle", trig_cycle, 0);
    check("rst_signature", signature, 0);
    reset = 1'b1;
    step();

    // Basic capture: trigger on 6, post_count 4.
    post_count = 5'd4; trig_ch = 3'd0; trig_value = 32'd6;
    do_arm();
    check("t1_armed", state, 1);
    sample(5, 1'b1);
    check("t1_no_trig", state, 1);
    exp_tc = cyc_model;
    sample(6, 1'b1);
    check("t1_capture", state, 2);
    check("t1_count1", count, 1);
    sample(7, 1'b1);
    sample(8, 1'b1);
    check("t1_count3", count, 3);
    sample(9, 1'b1);
    check("t1_done_state", state, 3);
    check("t1_done", done, 1);
    check("t1_count4", count, 4);
    check("t1_trig_cycle", trig_cycle, exp_tc);
`ifdef PIPE_TRACE_SIGNATURE_EN
    check("t1_signature", signature, 32'h35);
`else
    check("t1_signature", signature, 0);
`endif
    rd(4'd1, 3'd3, 32'd7 ^ 32'h30000);
    rd(4'd4, 3'd0, 0);
    rd(4'd0, 3'd7, 0);
    rd(4'd0, 3'd0, 6);
    rd(4'd1, 3'd0, 7);
    rd(4'd2, 3'd0, 8);
    rd(4'd3, 3'd0, 9);
    step();

    // Gapped capture, and a read attempted while ARMED.
    post_count = 5'd3; trig_value = 32'd20;
    do_arm();
    rd_en = 1'b1; rd_addr = 4'd0; rd_ch = 3'd0;
    step();
    rd_en = 1'b0;
    check("t2_armed_rd_valid", rd_valid, 0);
    check("t2_armed_rd_hold", rd_data, 9);
    sample(20, 1'b1);
    check("t2_capture", state, 2);
    sample(99, 1'b0);
    check("t2_gap_count", count, 1);
    sample(21, 1'b1);
    sample(98, 1'b0);
    check("t2_count2", count, 2);
    check("t2_not_done", state, 2);
    sample(22, 1'b1);
    check("t2_done", state, 3);
    check("t2_count3", count, 3);
    rd(4'd0, 3'd0, 20);
    rd(4'd1, 3'd0, 21);
    rd(4'd2, 3'd0, 22);
    rd(4'd1, 3'd5, 32'd21 ^ 32'h50000);
    step();

    // Out-of-range trigger channel never fires.
    post_count = 5'd4; trig_ch = 3'd7; trig_value = 32'h70000;
    do_arm();
    repeat (3) sample(0, 1'b1);
    check("t3_still_armed", state, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_abort_idle", state, 0);

    // post_count 0 means full depth; count saturates at DEPTH.
    trig_ch = 3'd2; post_count = 5'd0; trig_value = 32'd100 ^ 32'h20000;
    do_arm();
    for (int i = 0; i < D; i++) begin
      sample(32'(100 + i), 1'b1);
      if (i == D - 2) begin
        check("t4_count15", count, 15);
        check("t4_capture", state, 2);
      end
    end
    check("t4_done", state, 3);
    check("t4_count16", count, 16);
    sample(200, 1'b1);
    check("t4_count_hold", count, 16);
    rd(4'd15, 3'd2, 32'd115 ^ 32'h20000);
    rd(4'd0, 3'd0, 100);
    rd(4'd8, 3'd6, 32'd108 ^ 32'h60000);
    step();

    // Abort wins over arm; abort mid-capture keeps the data.
    abort = 1'b1;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("t5_arm_abort_idle", state, 0);
    trig_ch = 3'd0; post_count = 5'd8; trig_value = 32'd40;
    do_arm();
    sample(40, 1'b1);
    sample(41, 1'b1);
    check("t5_count2", count, 2);
    abort = 1'b1;
    probe = make_bus(42); probe_valid = 1'b1;
    step();
    abort = 1'b0; probe_valid = 1'b0;
    check("t5_abort_idle", state, 0);
    check("t5_abort_count", count, 2);
    rd(4'd0, 3'd0, 40);
    rd(4'd1, 3'd0, 41);
    rd(4'd2, 3'd0, 0);
    step();

    // Signature: values 1,2 then 1,1.
    trig_value = 32'd1; post_count = 5'd2;
    do_arm();
    sample(1, 1'b1);
    sample(2, 1'b1);
    check("t6_done", state, 3);
    check("t6_sig_12", signature, 0);
    do_arm();
    sample(1, 1'b1);
    sample(1, 1'b1);
`ifdef PIPE_TRACE_SIGNATURE_EN
    check("t6_sig_11", signature, 3);
`else
    check("t6_sig_11", signature, 0);
`endif

    // Asynchronous reset mid-capture.
    trig_value = 32'd50; post_count = 5'd8;
    do_arm();
    sample(50, 1'b1);
    sample(51, 1'b1);
    check("t7_capture", state, 2);
    probe = make_bus(52); probe_valid = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t7_rst_state", state, 0);
    check("t7_rst_count", count, 0);
    check("t7_rst_rd_valid", rd_valid, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_trig_cycle", trig_cycle, 0);
    step();
    reset = 1'b1; probe_valid = 1'b0;
    step();
    check("t7_post_rst_idle", state, 0);
    rd(4'd0, 3'd0, 0);
    step();
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
